// File: rtl/neosd_cmd_fsm.sv
// SD CMD-line engine: sends a 48-bit command frame with CRC7 and optionally receives and checks the card response.
// Define NEOSD_CMD_R2_EN to support 136-bit (R2) responses; without it rsp_type 10 is handled as a 48-bit response.
module neosd_cmd_fsm #(
    parameter int RSP_TIMEOUT = 64,
    parameter int NCC_TICKS   = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clkstrb_i,
    input  logic         sd_clk_en_i,
    output logic         sd_clk_req_o,
    input  logic         start_i,
    input  logic [5:0]   cmd_idx_i,
    input  logic [31:0]  arg_i,
    input  logic [1:0]   rsp_type_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         err_end_o,
    output logic [135:0] rsp_o,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe_o,
    input  logic         sd_cmd_i
);

`ifdef NEOSD_CMD_R2_EN
    localparam int RSP_W = 136;
`else
    localparam int RSP_W = 48;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX      = 3'd1,
        S_RX_WAIT = 3'd2,
        S_RX      = 3'd3,
        S_NCC     = 3'd4
    } state_t;

    // One CRC7 step, G = x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t             state_q;
    logic [39:0]        frame_q;
    logic [1:0]         rtype_q;
    logic [6:0]         crc_q;
    logic [7:0]         cnt_q;
    logic [RSP_W-1:0]   rsp_q;
    logic               cmd_q;
    logic               oe_q;
    logic               req_q;
    logic               busy_q;
    logic               done_q;
    logic               err_to_q;
    logic               err_crc_q;
    logic               err_end_q;

    logic               tick_s;
    logic [7:0]         rx_k_s;
    logic               rx_last_s;
    logic               rx_crc_s;

    assign tick_s = clkstrb_i & sd_clk_en_i;

    // Position of the response bit being received and whether it is the last / CRC-covered one
    always_comb begin
        rx_k_s    = cnt_q + 8'd1;
        rx_last_s = 1'b0;
        rx_crc_s  = 1'b0;
`ifdef NEOSD_CMD_R2_EN
        if (rtype_q == 2'b10) begin
            rx_last_s = (rx_k_s == 8'd136);
            rx_crc_s  = (rx_k_s >= 8'd9) && (rx_k_s <= 8'd128);
        end else begin
            rx_last_s = (rx_k_s == 8'd48);
            rx_crc_s  = (rx_k_s <= 8'd40);
        end
`else
        rx_last_s = (rx_k_s == 8'd48);
        rx_crc_s  = (rx_k_s <= 8'd40);
`endif
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            frame_q   <= 40'd0;
            rtype_q   <= 2'b00;
            crc_q     <= 7'd0;
            cnt_q     <= 8'd0;
            rsp_q     <= '0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_crc_q <= 1'b0;
            err_end_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        frame_q   <= {1'b0, 1'b1, cmd_idx_i, arg_i};
                        rtype_q   <= rsp_type_i;
                        crc_q     <= 7'd0;
                        cnt_q     <= 8'd0;
                        err_to_q  <= 1'b0;
                        err_crc_q <= 1'b0;
                        err_end_q <= 1'b0;
                        busy_q    <= 1'b1;
                        req_q     <= 1'b1;
                        state_q   <= S_TX;
                    end
                end
                S_TX: begin
                    if (tick_s) begin
                        if (cnt_q == 8'd48) begin
                            oe_q    <= 1'b0;
                            cmd_q   <= 1'b1;
                            cnt_q   <= 8'd0;
                            state_q <= (rtype_q == 2'b00) ? S_NCC : S_RX_WAIT;
                        end else begin
                            oe_q  <= 1'b1;
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q < 8'd40) begin
                                cmd_q   <= frame_q[39];
                                frame_q <= {frame_q[38:0], 1'b0};
                                crc_q   <= crc7_step(crc_q, frame_q[39]);
                            end else if (cnt_q < 8'd47) begin
                                cmd_q <= crc_q[6];
                                crc_q <= {crc_q[5:0], 1'b0};
                            end else begin
                                cmd_q <= 1'b1;
                            end
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (tick_s) begin
                        if (!sd_cmd_i) begin
                            // Start bit is 0, so feeding it to a zero CRC leaves the CRC at zero
                            rsp_q   <= '0;
                            crc_q   <= 7'd0;
                            cnt_q   <= 8'd1;
                            state_q <= S_RX;
                        end else if (cnt_q == 8'(RSP_TIMEOUT - 1)) begin
                            err_to_q <= 1'b1;
                            cnt_q    <= 8'd0;
                            state_q  <= S_NCC;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_RX: begin
                    if (tick_s) begin
                        rsp_q <= {rsp_q[RSP_W-2:0], sd_cmd_i};
                        cnt_q <= rx_k_s;
                        if (rx_crc_s) begin
                            crc_q <= crc7_step(crc_q, sd_cmd_i);
                        end
                        if (rx_last_s) begin
                            err_end_q <= ~sd_cmd_i;
                            err_crc_q <= (rtype_q != 2'b11) && (rsp_q[6:0] != crc_q);
                            cnt_q     <= 8'd0;
                            state_q   <= S_NCC;
                        end
                    end
                end
                S_NCC: begin
                    if (tick_s) begin
                        if (cnt_q == 8'(NCC_TICKS - 1)) begin
                            cnt_q   <= 8'd0;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sd_clk_req_o  = req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_to_q;
    assign err_crc_o     = err_crc_q;
    assign err_end_o     = err_end_q;
    assign sd_cmd_o      = cmd_q;
    assign sd_cmd_oe_o   = oe_q;
`ifdef NEOSD_CMD_R2_EN
    assign rsp_o = rsp_q;
`else
    assign rsp_o = {88'd0, rsp_q};
`endif

endmodule

// File: doc/neosd_cmd_fsm.md
Name: neosd_cmd_fsm

Overview:
SD CMD-line engine that sits directly downstream of the SD clock generator. It serialises a 48-bit command frame with CRC7, then optionally receives and checks the card response. All bit activity is paced by the generator's strobe, so CMD transitions and samples land on SD clock falling edges. It requests the SD clock for the whole transaction plus the trailing NCC gap.

Parameters:
RSP_TIMEOUT, 64, maximum ticks to wait for a response start bit (NCR) before flagging a timeout
NCC_TICKS, 8, trailing SD clock ticks kept after the end bit before the clock request is dropped

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
clkstrb_i  in  1  bit strobe from the clock generator
sd_clk_en_i  in  1  SD clock running and not stalled
sd_clk_req_o  out  1  SD clock request to the clock generator
start_i  in  1  start-command pulse; accepted only in IDLE
cmd_idx_i  in  6  command index
arg_i  in  32  command argument
rsp_type_i  in  2  00 none, 01 48-bit, 10 136-bit, 11 48-bit without CRC check (R3)
busy_o  out  1  transaction in progress
done_o  out  1  one-cycle completion pulse
err_timeout_o  out  1  no response start bit; valid with done_o, held until next start
err_crc_o  out  1  response CRC mismatch; held until next start
err_end_o  out  1  response end bit was 0; held until next start
rsp_o  out  136  received response, MSB first, right-aligned; the 48-bit case uses rsp_o[47:0]
sd_cmd_o  out  1  CMD output data
sd_cmd_oe_o  out  1  CMD output enable
sd_cmd_i  in  1  CMD input, externally synchronised

Behaviour:
- Tick = clkstrb_i && sd_clk_en_i. Every bit shift, counter step and sample occurs only on a tick. A deasserted sd_clk_en_i freezes all state.
- Reset values: sd_cmd_o=1, sd_cmd_oe_o=0, sd_clk_req_o=0, busy_o=0, done_o=0, all err_*=0, rsp_o=0. State is IDLE.
- IDLE, start_i=1:
  - latch frame {0,1,cmd_idx_i,arg_i}; latch rsp_type_i
  - clear err_* and the CRC register
  - assert busy_o and sd_clk_req_o in the next cycle
  - go to TX
- start_i outside IDLE is ignored.
- TX: on each tick drive sd_cmd_oe_o=1 and sd_cmd_o = next bit, MSB first.
  - Bits 47..8 also shift through CRC7 (G = x^7+x^3+1, init 0).
  - Bits 7..1 carry the CRC7; bit 0 is end bit 1.
  - On the tick after bit 0: sd_cmd_oe_o=0, sd_cmd_o=1.
  - rsp_type 00 goes to NCC; otherwise go to RX_WAIT with the wait counter cleared.
- RX_WAIT: sample sd_cmd_i on each tick.
  - Sample 0 = start bit: go to RX with bit count 1.
  - After RSP_TIMEOUT ticks with no 0 seen: set err_timeout_o and go to NCC.
- RX: shift sd_cmd_i into rsp_o LSB on each tick until 48 bits (or 136) are received, start bit included.
  - 48-bit CRC covers bits 47..8 and is compared with bits 7..1.
  - 136-bit CRC covers bits 127..8 and is compared with bits 7..1; bits 135..128 are excluded.
  - Check end bit 0 == 1, otherwise set err_end_o.
  - CRC mismatch sets err_crc_o, except for rsp_type 11, which skips the CRC check.
  - Then go to NCC.
- NCC: count NCC_TICKS ticks, then drop sd_clk_req_o, drop busy_o, pulse done_o for one clk_i cycle and return to IDLE.
- A start bit arriving on the very first RX_WAIT tick is valid.
- A timeout and an end error cannot both occur in one transaction.
- Reset mid-transaction returns immediately to reset values; no partial done_o is produced.

Optional Feature:
NEOSD_CMD_R2_EN
- Defined: rsp_type 10 receives 136 bits with the CRC rule above; rsp_o is fully used.
- Undefined: rsp_type 10 behaves as 01 (48 bits); rsp_o[135:48] stays 0; the 136-bit counter and CRC range logic are not built.

Test Plan:
1. CMD0, arg 0x00000000, rsp 00, strobe every 4 clk_i -> CMD bytes 40 00 00 00 00 95. Then 8 idle ticks, done_o, no errors, sd_clk_req_o deasserted.
2. CMD8, arg 0x000001AA, rsp 01; card replies 08 00 00 01 AA 13 after 5 ticks -> TX bytes 48 00 00 01 AA 87; rsp_o[47:0]=0x08000001AA13; no errors.
3. Same as scenario 2 but reply CRC byte 0x15 -> err_crc_o=1. Repeat with rsp 11 -> err_crc_o=0.
4. CMD55, rsp 01; sd_cmd_i held 1 -> err_timeout_o=1 after exactly 64 wait ticks, then done_o after 8 more ticks.
5. sd_clk_en_i=0 for 20 cycles mid-TX, plus start_i pulsed while busy -> frame bits unchanged and not duplicated; second start ignored.
6. Macro defined: CMD2, rsp 10, 136-bit reply with valid CRC -> rsp_o matches the reply, no errors. Reset asserted mid-RX -> all outputs return to reset values.
